div_mul_ctrl: RTL and testbench

Multicycle sequencer for the MIPS mult/div resource. It accepts a one-cycle start from unid_control when a DIV_MUL_REG_WRITE instruction is decoded (funct 011000 mult, 011010 div). It runs an iterative signed shift-add multiply or restoring divide over WIDTH cycles, then holds the result in HI/LO for mfhi/mflo and the div_mul_to_reg path. It reports busy, completion and divide-by-zero, so the main FSM can stall in its wait state.

---
 rtl/div_mul_pkg.sv | 17 +
 rtl/div_mul_step.sv | 35 +++
 rtl/div_mul_ctrl.sv | 126 ++++++++++++
 tb/tb_div_mul_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_mul_pkg.sv
// Shared constants for the mult/div sequencer and the decoder that drives it.
package div_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

endpackage

// File: rtl/div_mul_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
module div_mul_step
    import div_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: acc:quo is the 2W-bit product register, quo's low bit is the multiplier bit.
        sum      = quo[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
        // Divide: acc is the partial remainder, quo shifts the dividend out and quotient bits in.
        shifted  = {acc, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, opnd});
        diff     = shifted[WIDTH-1:0] - opnd;
        acc_next = {1'b0, sum[WIDTH:1]};
        quo_next = {sum[0], quo[WIDTH-1:1]};
        if (op == OP_DIV) begin
            acc_next = fits ? diff : shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/div_mul_ctrl.sv
// Multicycle signed mult/div sequencer feeding the HI/LO registers.
// Handshake: start is taken only while busy=0; done pulses one cycle when hi/lo are final (or div-by-zero aborts).
module div_mul_ctrl
    import div_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           state_dbg
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic             done_next, dz_next;
    logic             op_r, dz_r, neg_main, neg_rem;
    logic [WIDTH-1:0] acc, quo, opnd;
    logic [WIDTH-1:0] acc_next, quo_next;
    logic [CW-1:0]    cnt;

    logic [2*WIDTH-1:0] prod_mag, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, hi_fix, lo_fix;

    div_mul_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_r),
        .acc      (acc),
        .quo      (quo),
        .opnd     (opnd),
        .acc_next (acc_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        dz_next    = 1'b0;
        case (state)
            IDLE: if (start) state_next = PREP;
            // Div-by-zero still passes through FIX so the abort reports on the same edge slot.
            PREP: state_next = (op_r == OP_DIV && opnd == '0) ? FIX : CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX: begin
                state_next = IDLE;
                done_next  = 1'b1;
                dz_next    = dz_r;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod_mag = {acc, quo};
        prod_s   = neg_main ? -prod_mag : prod_mag;
        quo_s    = neg_main ? -quo : quo;
        rem_s    = neg_rem ? -acc : acc;
        hi_fix   = (op_r == OP_DIV) ? rem_s : prod_s[2*WIDTH-1:WIDTH];
        lo_fix   = (op_r == OP_DIV) ? quo_s : prod_s[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            op_r     <= OP_MULT;
            dz_r     <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            acc      <= '0;
            quo      <= '0;
            opnd     <= '0;
            cnt      <= '0;
        end else begin
            done     <= done_next;
            div_zero <= dz_next;
            case (state)
                IDLE: if (start) begin
                    // quo holds the dividend or the multiplier; opnd the divisor or multiplicand.
                    op_r <= op;
                    quo  <= (op == OP_DIV) ? a : b;
                    opnd <= (op == OP_DIV) ? b : a;
                    dz_r <= 1'b0;
                end
                PREP: begin
                    neg_main <= quo[WIDTH-1] ^ opnd[WIDTH-1];
                    neg_rem  <= quo[WIDTH-1];
                    dz_r     <= (op_r == OP_DIV) && (opnd == '0);
                    quo      <= quo[WIDTH-1] ? -quo : quo;
                    opnd     <= opnd[WIDTH-1] ? -opnd : opnd;
                    acc      <= '0;
                    cnt      <= '0;
                end
                CALC: begin
                    acc <= acc_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: if (!dz_r) begin
                    hi <= hi_fix;
                    lo <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_div_mul_ctrl.sv
// Bench for div_mul_ctrl: directed table, hand-written corner sequences, randomized ops vs a signed-arithmetic model.
module tb_div_mul_ctrl;
    import div_mul_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_zero;
    state_t       state_dbg;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;
    vec_t         tbl[10];

    div_mul_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: architectural HI/LO from signed integer arithmetic
    function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] ma, input logic [W-1:0] mb);
        longint sa, sb, p, q, r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (o == OP_MULT) begin
            p = sa * sb;
            return {1'b0, p[63:0]};
        end
        if (mb == '0) return {1'b1, model_hi, model_lo};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    // drivers
    task automatic issue(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic edz, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        exp_q.push_back({edz, ehi, elo});
        if (!edz) begin
            model_hi = ehi;
            model_lo = elo;
        end
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_low_after_start", done, 0);
    endtask

    task automatic issue_model(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib);
        logic [2*W:0] e;
        e = model(o, ia, ib);
        issue(o, ia, ib, e[2*W], e[2*W-1:W], e[W-1:0]);
    endtask

    // scoreboard: waits for done, checks latency, busy and result against the expected queue
    task automatic wait_done(input int inject_at);
        logic [2*W:0] e;
        int  n;
        bit  seen, busy_ok;
        int  exp_lat;
        n = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        e = exp_q.pop_front();
        exp_lat = e[2*W] ? 2 : LAT;
        while (n < 100 && !seen) begin
            if (n == inject_at) begin
                start = 1'b1;
                op    = 1'($urandom_range(0, 1));
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check("done_seen", seen, 1);
        check("latency", n, exp_lat);
        check("busy_during_op", busy_ok, 1);
        check("busy_at_done", busy, 0);
        check("div_zero", div_zero, e[2*W]);
        check("hi", hi, e[2*W-1:W]);
        check("lo", lo, e[W-1:0]);
    endtask

    initial begin
        tbl[0] = '{OP_MULT, 32'd7,          32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1] = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[2] = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD};
        tbl[3] = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
        tbl[4] = '{OP_MULT, 32'h80000000,   32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
        tbl[5] = '{OP_MULT, 32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001};
        tbl[6] = '{OP_MULT, 32'h7FFFFFFF,   32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001};
        tbl[7] = '{OP_DIV,  32'd100,        32'd7,        1'b0, 32'h00000002, 32'h0000000E};
        tbl[8] = '{OP_DIV,  32'd5,          32'd0,        1'b1, 32'h00000002, 32'h0000000E};
        tbl[9] = '{OP_MULT, 32'd7,          32'd3,        1'b0, 32'h00000000, 32'h00000015};

        // reset
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div_zero", div_zero, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_state", state_dbg, IDLE);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dz, tbl[i].hi, tbl[i].lo);
            wait_done(-1);
            @(posedge clk);
            #1;
            check("done_one_cycle", done, 0);
            check("div_zero_one_cycle", div_zero, 0);
            check("idle_after_done", busy, 0);
        end

        // start pulsed mid-CALC must be ignored
        issue_model(OP_MULT, 32'd12345, 32'hFFFFFD5A);
        wait_done(10);
        @(posedge clk);
        #1;
        check("no_queued_op", busy, 0);

        // start in the done cycle is accepted back-to-back
        issue_model(OP_DIV, 32'hFFFF0000, 32'd9);
        wait_done(-1);
        issue_model(OP_MULT, 32'hDEADBEEF, 32'h00001234);
        wait_done(-1);

        // asynchronous reset in the middle of CALC aborts without done
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd7;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done, 0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue_model(OP_MULT, 32'd7, 32'd3);
        wait_done(-1);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            logic         ro;
            logic [W-1:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) - W'(20) : W'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = W'($urandom_range(0, 16)) - W'(8);
                default: rb = W'($urandom);
            endcase
            issue_model(ro, ra, rb);
            wait_done(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
